// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the accumulator CPU bus. Answers rd/wr strobes
//   with registered read data and a write acknowledge. Program/data words live
//   in an internal 2^ADDR_W x DATA_W array that a side-band preload port can
//   fill while the CPU is idle. Optional read wait states (WAIT_CYCLES).
//
//   Optional feature macro: MEM_RESP_PARITY_EN
//     defined   : each word carries an even-parity bit; perr pulses on a
//                 parity mismatch, aligned with the new rdata.
//     undefined : no parity storage, perr tied to 0.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   rd / wr      in   read / write strobes from the controller
//   addr         in   word address for the CPU access
//   wdata        in   CPU write data
//   pl_en        in   preload write enable (honoured only in IDLE, no strobe)
//   pl_addr      in   preload address
//   pl_data      in   preload data
//   rdata        out  registered read data
//   rdata_valid  out  rdata holds mem[addr] for the current read
//   busy         out  read wait states in progress
//   wr_ack       out  one-cycle pulse after a CPU write commits
//   err          out  one-cycle pulse on a protocol violation
//   perr         out  one-cycle pulse on a read parity mismatch
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pl_en,
  input  logic [ADDR_W-1:0] pl_addr,
  input  logic [DATA_W-1:0] pl_data,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              wr_ack,
  output logic              err,
  output logic              perr
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef MEM_RESP_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  // Counter preload; the WAIT state itself accounts for one cycle.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RDATA, S_WACK} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              busy_q, busy_d;
  logic              wr_ack_q, wr_ack_d;
  logic              err_q, err_d;
  logic [MEM_W-1:0]  mem_q [DEPTH];

  logic              capture;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] wdata_sel;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  rd_word;

  assign rd_word = mem_q[addr];

`ifdef MEM_RESP_PARITY_EN
  assign mem_wdata = {^wdata_sel, wdata_sel};
`else
  assign mem_wdata = wdata_sel;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    wr_ack_d  = 1'b0;
    err_d     = 1'b0;
    capture   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr;
    wdata_sel = wdata;

    if (rd && wr) begin
      // Conflicting strobes win over everything: no write, back to IDLE.
      err_d   = 1'b1;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (wr) begin
            mem_we   = 1'b1;
            wr_ack_d = 1'b1;
            state_d  = S_WACK;
          end else if (rd) begin
            if (WAIT_CYCLES == 0) begin
              capture = 1'b1;
              state_d = S_RDATA;
            end else begin
              cnt_d   = WAIT_LOAD;
              state_d = S_WAIT;
            end
          end else if (pl_en) begin
            mem_we    = 1'b1;
            mem_waddr = pl_addr;
            wdata_sel = pl_data;
          end
        end
        S_WAIT: begin
          if (wr) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (!rd) begin
            state_d = S_IDLE;
          end else if (cnt_q == 4'd0) begin
            capture = 1'b1;
            state_d = S_RDATA;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_RDATA: begin
          if (wr) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (!rd) begin
            state_d = S_IDLE;
          end else begin
            // Re-read every cycle so an address change shows one cycle later.
            capture = 1'b1;
          end
        end
        S_WACK: begin
          // Held wr does not write again; wait for it to drop.
          if (!wr) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Preload is only legal in IDLE with no strobe; otherwise it is dropped.
    if (pl_en && ((state_q != S_IDLE) || rd || wr)) err_d = 1'b1;

    if (capture) rdata_d = rd_word[DATA_W-1:0];

    rdata_valid_d = (state_d == S_RDATA);
    busy_d        = (state_d == S_WAIT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      wr_ack_q      <= 1'b0;
      err_q         <= 1'b0;
      // NOTE: the array is cleared on reset because every word must read as 0
      // afterwards; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      busy_q        <= busy_d;
      wr_ack_q      <= wr_ack_d;
      err_q         <= err_d;
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end
  end

`ifdef MEM_RESP_PARITY_EN
  logic perr_q, perr_d;

  // Even parity: data bits plus stored parity bit must XOR to 0.
  always_comb begin
    perr_d = capture & (^rd_word);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end

  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign busy        = busy_q;
  assign wr_ack      = wr_ack_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Scoreboard bench for mem_responder. Stimulus pushes the expected read data,
//   write acks and error pulses into queues; a monitor on the falling edge pops
//   and compares whenever the DUT raises rdata_valid / wr_ack / err.
//   dut   : WAIT_CYCLES=0, driven by rd
//   dut_w : WAIT_CYCLES=2, driven by rd_w (all other inputs shared)
// -----------------------------------------------------------------------------
module tb_mem_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rd = 1'b0, rd_w = 1'b0, wr = 1'b0, pl_en = 1'b0;
  logic [4:0] addr = '0, pl_addr = '0;
  logic [7:0] wdata = '0, pl_data = '0;

  logic [7:0] rdata, rdata_w;
  logic       rdata_valid, busy, wr_ack, err, perr;
  logic       rdata_valid_w, busy_w, wr_ack_w, err_w, perr_w;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb   [$];
  logic [7:0] sb_w [$];
  int         ack_q[$];
  int         err_q[$];

  always #5 clock = ~clock;

  mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(0)) dut (
    .clock(clock), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .pl_en(pl_en), .pl_addr(pl_addr), .pl_data(pl_data),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .wr_ack(wr_ack),
    .err(err), .perr(perr)
  );

  mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(2)) dut_w (
    .clock(clock), .reset(reset), .rd(rd_w), .wr(wr), .addr(addr), .wdata(wdata),
    .pl_en(pl_en), .pl_addr(pl_addr), .pl_data(pl_data),
    .rdata(rdata_w), .rdata_valid(rdata_valid_w), .busy(busy_w), .wr_ack(wr_ack_w),
    .err(err_w), .perr(perr_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares against the scoreboards whenever an output is presented.
  always @(negedge clock) begin
    if (reset) begin
      if (rdata_valid) begin
        if (sb.size() == 0) check("rdata_valid_unexpected", rdata_valid, 1'b0);
        else begin
          check("rdata", rdata, sb.pop_front());
          check("perr", perr, 1'b0);
        end
      end
      if (rdata_valid_w) begin
        if (sb_w.size() == 0) check("rdata_valid_w_unexpected", rdata_valid_w, 1'b0);
        else begin
          check("rdata_w", rdata_w, sb_w.pop_front());
          check("perr_w", perr_w, 1'b0);
        end
      end
      if (wr_ack) begin
        if (ack_q.size() == 0) check("wr_ack_unexpected", wr_ack, 1'b0);
        else void'(ack_q.pop_front());
      end
      if (err) begin
        if (err_q.size() == 0) check("err_unexpected", err, 1'b0);
        else void'(err_q.pop_front());
      end
    end
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_sb"},  sb.size(),    0);
    check({tag, "_ack"}, ack_q.size(), 0);
    check({tag, "_err"}, err_q.size(), 0);
  endtask

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    cyc();
    pl_en = 1'b0;
  endtask

  // Hold rd for n cycles at address a, expecting d on every valid cycle.
  task automatic do_read(input logic [4:0] a, input int n, input logic [7:0] d);
    rd = 1'b1; addr = a;
    for (int i = 0; i < n; i++) begin
      cyc();
      sb.push_back(d);
      if (i == 0) check("read_latency_valid", rdata_valid, 1'b1);
    end
    rd = 1'b0;
    cyc();
    check("valid_drop", rdata_valid, 1'b0);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    wr = 1'b1; addr = a; wdata = d;
    cyc();
    ack_q.push_back(int'(a));
    check("wr_ack_pulse", wr_ack, 1'b1);
    wr = 1'b0;
    cyc();
    check("wr_ack_clear", wr_ack, 1'b0);
  endtask

  initial begin
    // Reset state.
    #1;
    check("rst_rdata",       rdata,       8'h00);
    check("rst_rdata_valid", rdata_valid, 1'b0);
    check("rst_busy",        busy,        1'b0);
    check("rst_wr_ack",      wr_ack,      1'b0);
    check("rst_err",         err,         1'b0);
    check("rst_perr",        perr,        1'b0);
    cyc(); cyc();
    reset = 1'b1;
    cyc();

    // Reset asserted mid-read clears everything immediately.
    preload(5'd3, 8'hA5);
    rd = 1'b1; addr = 5'd3;
    cyc();
    sb.push_back(8'hA5);
    #6;  // past the monitor's falling edge, before the next rising edge
    reset = 1'b0;
    #1;
    check("midrd_rdata",       rdata,         8'h00);
    check("midrd_rdata_valid", rdata_valid,   1'b0);
    check("midrd_busy",        busy,          1'b0);
    check("midrd_wr_ack",      wr_ack,        1'b0);
    check("midrd_err",         err,           1'b0);
    check("midrd_perr",        perr,          1'b0);
    check("midrd_busy_w",      busy_w,        1'b0);
    rd = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    do_read(5'd3, 1, 8'h00);  // array cleared by reset
    check_drained("after_reset");

    // Preload and 3-cycle read.
    preload(5'd3, 8'hA5);
    do_read(5'd3, 3, 8'hA5);
    check_drained("preload_read");

    // Write then read back.
    do_write(5'd5, 8'h3C);
    do_read(5'd5, 1, 8'h3C);
    check_drained("write_read");

    // Wait states on the WAIT_CYCLES=2 instance.
    rd_w = 1'b1; addr = 5'd3;
    cyc();
    check("w_busy_n0",  busy_w,        1'b1);
    check("w_valid_n0", rdata_valid_w, 1'b0);
    cyc();
    check("w_busy_n1",  busy_w,        1'b1);
    check("w_valid_n1", rdata_valid_w, 1'b0);
    cyc();
    sb_w.push_back(8'hA5);
    check("w_busy_n2",  busy_w,        1'b0);
    check("w_valid_n2", rdata_valid_w, 1'b1);
    rd_w = 1'b0;
    cyc();
    check("w_valid_drop", rdata_valid_w, 1'b0);
    // Abort during WAIT: no data ever.
    rd_w = 1'b1;
    cyc();
    check("w_abort_busy", busy_w, 1'b1);
    rd_w = 1'b0;
    cyc();
    check("w_abort_busy_clr", busy_w,        1'b0);
    check("w_abort_valid0",   rdata_valid_w, 1'b0);
    cyc();
    check("w_abort_valid1",   rdata_valid_w, 1'b0);
    check("w_sb_drained",     sb_w.size(),   0);

    // Conflict: err pulse, no write.
    rd = 1'b1; wr = 1'b1; addr = 5'd5; wdata = 8'hFF;
    cyc();
    err_q.push_back(1);
    check("conflict_err",   err,         1'b1);
    check("conflict_noack", wr_ack,      1'b0);
    rd = 1'b0; wr = 1'b0;
    cyc();
    check("conflict_err_clr", err,         1'b0);
    check("conflict_valid",   rdata_valid, 1'b0);
    do_read(5'd5, 1, 8'h3C);
    check_drained("conflict");

    // Address change while in RDATA.
    rd = 1'b1; addr = 5'd3;
    cyc(); sb.push_back(8'hA5);
    cyc(); sb.push_back(8'hA5);
    addr = 5'd5;
    cyc(); sb.push_back(8'h3C);
    cyc(); sb.push_back(8'h3C);
    rd = 1'b0;
    cyc();
    check("addr_chg_valid_drop", rdata_valid, 1'b0);
    check_drained("addr_change");

    // Preload together with a strobe is ignored and flagged.
    rd = 1'b1; addr = 5'd3;
    pl_en = 1'b1; pl_addr = 5'd7; pl_data = 8'h77;
    cyc();
    sb.push_back(8'hA5);
    err_q.push_back(1);
    check("pl_strobe_err", err, 1'b1);
    rd = 1'b0; pl_en = 1'b0;
    cyc();
    do_read(5'd7, 1, 8'h00);
    check_drained("pl_strobe");

    // Full write/read sweep (exercises parity when the macro is defined).
    for (int a = 0; a < 32; a++) begin
      logic [7:0] v;
      v = 8'(a) ^ 8'h5A;
      do_write(5'(a), v);
    end
    for (int a = 0; a < 32; a++) begin
      logic [7:0] v;
      v = 8'(a) ^ 8'h5A;
      do_read(5'(a), 1, v);
    end
    check_drained("sweep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the 8-opcode accumulator CPU bus. It answers the controller's `rd`/`wr` strobes with registered read data and write acknowledgement, holding program and data words in an internal array. Optional read wait states are supported. A side-band preload port fills the array before the CPU is released from reset.

## Interface
- `ADDR_W`, 5: address width; array depth is 2^ADDR_W words.
- `DATA_W`, 8: word width.
- `WAIT_CYCLES`, 0: read wait states inserted before first valid data (0..15).
- `clock`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state and outputs.
- `rd`  in  1  read strobe from controller; held high across a read.
- `wr`  in  1  write strobe from controller; nominally one cycle.
- `addr`  in  ADDR_W  word address, sampled every cycle that a strobe is sampled.
- `wdata`  in  DATA_W  write data (CPU drives it while its `data_e` is high).
- `pl_en`  in  1  preload write enable.
- `pl_addr`  in  ADDR_W  preload address.
- `pl_data`  in  DATA_W  preload data.
- `rdata`  out  DATA_W  registered read data.
- `rdata_valid`  out  1  `rdata` holds `mem[addr]` for the current read.
- `busy`  out  1  high in WAIT.
- `wr_ack`  out  1  one-cycle pulse after a write is committed.
- `err`  out  1  one-cycle pulse on a protocol violation.
- `perr`  out  1  parity error on read (see Configuration).

## Operation
- States: IDLE, WAIT, RDATA, WACK. Wait counter: 4 bits.
- Conflict (`rd` and `wr` both high, any state): `err`=1 next cycle, no array write, go to IDLE.
- IDLE:
  - `wr` only: `mem[addr]<=wdata` on this edge, go to WACK.
  - `rd` only, WAIT_CYCLES=0: `rdata<=mem[addr]`, go to RDATA.
  - `rd` only, WAIT_CYCLES>0: load counter with WAIT_CYCLES-1, go to WAIT.
  - `pl_en` with no strobe: `mem[pl_addr]<=pl_data`.
- `pl_en` outside IDLE, or together with a strobe: ignored, `err` pulse.
- WAIT:
  - `rd` low: abort to IDLE, no data.
  - `wr` high: `err` pulse, go to IDLE.
  - Counter 0: `rdata<=mem[addr]` (addr at this edge), go to RDATA.
  - Otherwise: decrement counter.
- RDATA:
  - `rd` high: `rdata<=mem[addr]` every cycle, so an address change is reflected one cycle later.
  - `rd` low: go to IDLE.
  - `wr` high: `err` pulse, go to IDLE.
- WACK: stay in WACK while `wr` is high; no further write takes place. `wr` low: go to IDLE.
- Array width is exactly DATA_W (plus the parity bit when enabled). Addresses are never out of range, since depth is 2^ADDR_W.

## Timing
- Reset values: `rdata`=0, `rdata_valid`=0, `busy`=0, `wr_ack`=0, `err`=0, `perr`=0, state IDLE, counter 0, every array word 0.
- Reset asserted mid-read or mid-write: immediate return to reset values. A write sampled on the same edge that reset asserts is lost.
- `rdata_valid` = (state==RDATA), registered. `busy` = (state==WAIT).
- Read latency, WAIT_CYCLES=0: `rd` sampled at edge N, then `rdata` and `rdata_valid` valid after edge N. This meets the controller's fetch, where `ld_ir` is high one cycle after `rd` rises.
- Read latency, WAIT_CYCLES=W: valid after edge N+W.
- Write: committed at the sampling edge N; `wr_ack` high for the cycle after edge N only.
- `err` and `perr`: one-cycle pulses, registered.
- Write and subsequent read of the same address: the read returns the new value (the write commits first).

## Configuration
- `MEM_RESP_PARITY_EN` defined:
  - Each word stores an extra even-parity bit, computed on both CPU writes and preloads.
  - Every `rdata` capture recomputes parity; a mismatch sets `perr`=1 for one cycle, aligned with the new `rdata`.
  - A test-only corruption path is not provided, so `perr` stays 0 in correct operation.
- Not defined: no parity storage; `perr` is tied to 0.

## Test plan
- Reset and preload:
  - Assert `reset`=0 mid-read → all outputs 0 immediately.
  - Release reset; preload `mem[3]`=8'hA5.
  - `rd`=1, `addr`=3 for 3 cycles → `rdata`=8'hA5 with `rdata_valid`=1 from the cycle after `rd` rises; `rdata_valid` drops one cycle after `rd` falls.
- Write/read-back: `wr`=1 one cycle with `addr`=5, `wdata`=8'h3C → `wr_ack` pulse next cycle; then read `addr`=5 → 8'h3C.
- Wait states: WAIT_CYCLES=2, read `addr`=3 → `busy`=1 for 2 cycles; `rdata_valid` rises at edge N+2; `rd` dropped during WAIT → IDLE, `rdata_valid` never set.
- Conflict: `rd`=`wr`=1 with `addr`=5, `wdata`=8'hFF → `err` pulse; `mem[5]` still 8'h3C.
- Address change during RDATA: hold `rd`, switch `addr` 3→5 → `rdata` changes 8'hA5→8'h3C one cycle later.
- Parity (macro defined): run full write/read sweep over 32 addresses with pattern `addr^8'h5A` → all data match, `perr` never asserts.
